// File: rtl/riscv_pkg.sv
// Shared core definitions used by the retirement trace buffer: record layout,
// streaming state encoding and header bit positions.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int HDR_SEQ_LSB = 16;
    localparam int HDR_HASREG  = 7;
    localparam int HDR_HASMEM  = 6;

    // One retired instruction as held in the trace FIFO.
    typedef struct packed {
        logic [15:0]     seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } trace_rec_t;

    // Beat currently presented on the stream (IDLE = nothing in flight).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PC    = 3'd2,
        ST_INSTR = 3'd3,
        ST_RDATA = 3'd4,
        ST_MADDR = 3'd5,
        ST_MDATA = 3'd6
    } trace_state_e;

    // Header word: seq in the top half, presence flags and rd below.
    function automatic logic [XLEN-1:0] trace_header(input trace_rec_t rec);
        logic [XLEN-1:0] hdr_v;
        hdr_v                        = '0;
        hdr_v[HDR_SEQ_LSB +: 16]     = rec.seq;
        hdr_v[HDR_HASREG]            = (rec.reg_addr != 5'd0);
        hdr_v[HDR_HASMEM]            = (rec.mem_addr != '0);
        hdr_v[4:0]                   = rec.reg_addr;
        return hdr_v;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records with occupancy count. Push while full and
// pop while empty are ignored; the caller gates both anyway.
module trace_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  trace_rec_t               wr_rec,
    input  logic                     pop,
    output trace_rec_t               rd_rec,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign rd_rec    = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Record storage; no reset needed since only counted entries are read
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_rec;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            else           rd_ptr_r <= rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: captures one record per retired instruction and
// streams it as XLEN-bit beats (HDR, PC, INSTR, RDATA, MADDR, MDATA).
// Optional build macro TRACE_COMPRESS_EN: skip RDATA when no register write
// and MADDR/MDATA when no memory access (3..6 beats per record).
module retire_trace_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   update_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic [XLEN-1:0]        instr_i,
    input  logic [4:0]             reg_addr_i,
    input  logic [XLEN-1:0]        reg_data_i,
    input  logic [XLEN-1:0]        mem_addr_i,
    input  logic [XLEN-1:0]        mem_data_i,
    output logic                   tvalid_o,
    output logic [XLEN-1:0]        tdata_o,
    output logic                   tlast_o,
    input  logic                   tready_i,
    output logic                   overflow_o,
    output logic [15:0]            drop_cnt_o,
    output logic [$clog2(DEPTH):0] level_o
);

    // Field word for a given beat; absent fields read as zero.
    function automatic logic [XLEN-1:0] beat_data(input trace_state_e st, input trace_rec_t rec);
        logic [XLEN-1:0] d_v;
        case (st)
            ST_HDR:   d_v = trace_header(rec);
            ST_PC:    d_v = rec.pc;
            ST_INSTR: d_v = rec.instr;
            ST_RDATA: d_v = (rec.reg_addr != 5'd0) ? rec.reg_data : '0;
            ST_MADDR: d_v = rec.mem_addr;
            ST_MDATA: d_v = (rec.mem_addr != '0) ? rec.mem_data : '0;
            default:  d_v = '0;
        endcase
        return d_v;
    endfunction

    // Beat that follows st within the same record (only used when st is not last).
    function automatic trace_state_e next_beat(input trace_state_e st, input trace_rec_t rec);
        trace_state_e n_v;
        case (st)
            ST_HDR:   n_v = ST_PC;
            ST_PC:    n_v = ST_INSTR;
`ifdef TRACE_COMPRESS_EN
            ST_INSTR: n_v = (rec.reg_addr != 5'd0) ? ST_RDATA : ST_MADDR;
`else
            ST_INSTR: n_v = ST_RDATA;
`endif
            ST_RDATA: n_v = ST_MADDR;
            ST_MADDR: n_v = ST_MDATA;
            default:  n_v = ST_IDLE;
        endcase
        return n_v;
    endfunction

    // True when st is the final beat emitted for rec.
    function automatic logic is_last(input trace_state_e st, input trace_rec_t rec);
        logic last_v;
`ifdef TRACE_COMPRESS_EN
        logic has_reg_v;
        logic has_mem_v;
        has_reg_v = (rec.reg_addr != 5'd0);
        has_mem_v = (rec.mem_addr != '0);
        case (st)
            ST_INSTR: last_v = !has_reg_v && !has_mem_v;
            ST_RDATA: last_v = !has_mem_v;
            ST_MDATA: last_v = 1'b1;
            default:  last_v = 1'b0;
        endcase
`else
        last_v = (st == ST_MDATA) && (rec.seq == rec.seq);
`endif
        return last_v;
    endfunction

    trace_rec_t                 cap_rec_s;
    trace_rec_t                 head_s;
    trace_rec_t                 hold_r;
    trace_state_e               state_r;
    trace_state_e               nxt_state_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       drop_s;
    logic                       full_s;
    logic                       empty_s;
    logic [$clog2(DEPTH):0]     count_s;
    logic [15:0]                seq_r;
    logic                       overflow_r;
    logic [15:0]                drop_cnt_r;
    logic                       tvalid_r;
    logic [XLEN-1:0]            tdata_r;
    logic                       tlast_r;

    // Full is the registered count, so a same-cycle pop never rescues a push
    assign push_s = update_i && !full_s;
    assign drop_s = update_i && full_s;

    // Assemble the record presented by the core this cycle
    always_comb begin
        cap_rec_s          = '0;
        cap_rec_s.seq      = seq_r;
        cap_rec_s.pc       = pc_i;
        cap_rec_s.instr    = instr_i;
        cap_rec_s.reg_addr = reg_addr_i;
        cap_rec_s.reg_data = reg_data_i;
        cap_rec_s.mem_addr = mem_addr_i;
        cap_rec_s.mem_data = mem_data_i;
    end

    // Pop when idle with work waiting, or when the last beat is being accepted
    always_comb begin
        pop_s       = 1'b0;
        nxt_state_s = next_beat(state_r, hold_r);
        if (state_r == ST_IDLE) begin
            pop_s = !empty_s;
        end else if (tvalid_r && tready_i && tlast_r) begin
            pop_s = !empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (push_s),
        .wr_rec (cap_rec_s),
        .pop    (pop_s),
        .rd_rec (head_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (count_s)
    );

    // Sequence counter plus sticky overflow and saturating drop counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_r      <= 16'd0;
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (update_i) seq_r <= seq_r + 16'd1;
            else          seq_r <= seq_r;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
                else                        drop_cnt_r <= drop_cnt_r;
            end else begin
                overflow_r <= overflow_r;
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Streaming FSM with registered beat outputs; state names the beat on the wire
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            hold_r   <= '0;
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            tlast_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_r <= ST_HDR;
                        hold_r  <= head_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    if (!tvalid_r) begin
                        // First cycle after leaving IDLE: present the header
                        tvalid_r <= 1'b1;
                        tdata_r  <= beat_data(state_r, hold_r);
                        tlast_r  <= is_last(state_r, hold_r);
                    end else if (tready_i) begin
                        if (tlast_r && !empty_s) begin
                            state_r  <= ST_HDR;
                            hold_r   <= head_s;
                            tdata_r  <= beat_data(ST_HDR, head_s);
                            tlast_r  <= is_last(ST_HDR, head_s);
                        end else if (tlast_r) begin
                            state_r  <= ST_IDLE;
                            tvalid_r <= 1'b0;
                            tdata_r  <= '0;
                            tlast_r  <= 1'b0;
                        end else begin
                            state_r  <= nxt_state_s;
                            tdata_r  <= beat_data(nxt_state_s, hold_r);
                            tlast_r  <= is_last(nxt_state_s, hold_r);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
            endcase
        end
    end

    assign tvalid_o   = tvalid_r;
    assign tdata_o    = tdata_r;
    assign tlast_o    = tlast_r;
    assign overflow_o = overflow_r;
    assign drop_cnt_o = drop_cnt_r;
    assign level_o    = count_s;

endmodule
